// File: rtl/cpu_pkg.sv
// Types and constants shared between the fetch stage and the opcode decoder.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam logic [15:0] NOP_WORD    = 16'h0800;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;

    localparam logic [4:0]  OP_NOP  = 5'b00001;
    localparam logic [4:0]  OP_ADD  = 5'b00010;
    localparam logic [4:0]  OP_SUB  = 5'b00011;
    localparam logic [4:0]  OP_LD   = 5'b00100;
    localparam logic [4:0]  OP_ST   = 5'b00101;
    localparam logic [4:0]  OP_BEQ  = 5'b00110;
    localparam logic [4:0]  OP_BNE  = 5'b00111;
    localparam logic [4:0]  OP_JAL  = 5'b01000;
    localparam logic [4:0]  OP_JALR = 5'b01001;

    function automatic logic [4:0] opcode_of(input logic [15:0] word);
        return word[15:11];
    endfunction

endpackage

// File: rtl/fetch_stage_pc_next.sv
// Next-PC selection: redirect target, sequential advance, or hold.
module pc_next (
    input  logic [15:0] i_pc,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    input  logic        i_advance,
    output logic [15:0] o_next_pc,
    output logic [15:0] o_pc_plus2,
    output logic        o_misaligned
);

    logic [15:0] w_pc_plus2;

    // Wraps modulo 2^16 by construction.
    assign w_pc_plus2   = i_pc + 16'd2;
    assign o_pc_plus2   = w_pc_plus2;
    assign o_misaligned = i_redirect && i_redirect_pc[0];

    always_comb begin
        o_next_pc = i_pc;
        if (i_redirect)
            o_next_pc = i_redirect_pc;
        else if (i_advance)
            o_next_pc = w_pc_plus2;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, talks to a variable-latency instruction
// memory and holds one fetched word in the instruction register for decode.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_in,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_stall,
    input  logic        imem_done,
    output logic [15:0] instr,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    output logic        fetch_err,
    output logic        halted
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic         r_halt_pend;
    logic         w_next_halt_pend;

    logic [15:0]  r_pc;
    logic [15:0]  r_ir;
    logic [15:0]  r_pc_plus2;
    logic         r_valid;
    logic         r_err;

    logic         w_consume;
    logic         w_ir_free;
    logic         w_accept;
    logic         w_redir;
    logic         w_halt_req;
    logic         w_capture;
    logic         w_drain_needed;
    logic [15:0]  w_next_pc;
    logic [15:0]  w_pc_plus2;
    logic         w_misaligned;

    assign w_consume  = r_valid && !stall_in;
    assign w_ir_free  = !r_valid || w_consume;
    assign w_accept   = imem_rd && !imem_stall;
    assign w_redir    = redirect && (r_state != HALTED);
    assign w_halt_req = halt_in && w_consume && !redirect;

    // A request is still in flight if we are waiting on it, one was just
    // accepted without completing, or a squashed one has not yet returned.
    assign w_drain_needed = (r_state == WAIT)
                         || ((r_state == FETCH) && w_accept && !imem_done)
                         || ((r_state == DRAIN) && !imem_done);

    assign w_capture = !w_redir && !w_halt_req
                    && (((r_state == FETCH) && w_accept && imem_done)
                     || ((r_state == WAIT) && imem_done));

    pc_next u_pc_next (
        .i_pc          (r_pc),
        .i_redirect    (w_redir),
        .i_redirect_pc (redirect_pc),
        .i_advance     (w_capture),
        .o_next_pc     (w_next_pc),
        .o_pc_plus2    (w_pc_plus2),
        .o_misaligned  (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FETCH;
            r_halt_pend <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_halt_pend <= w_next_halt_pend;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_redir) begin
            if (w_misaligned)
                w_next_state = HALTED;
            else if (w_drain_needed)
                w_next_state = DRAIN;
            else if (r_halt_pend)
                w_next_state = HALTED;
            else
                w_next_state = FETCH;
        end else if (w_halt_req) begin
            w_next_state = w_drain_needed ? DRAIN : HALTED;
        end else begin
            case (r_state)
                FETCH:   if (w_accept && !imem_done) w_next_state = WAIT;
                WAIT:    if (imem_done) w_next_state = FETCH;
                DRAIN:   if (imem_done) w_next_state = r_halt_pend ? HALTED : FETCH;
                default: w_next_state = HALTED;
            endcase
        end
        w_next_halt_pend = (w_next_state == DRAIN) && (r_halt_pend || w_halt_req);
    end

    always_comb begin
        imem_rd     = (r_state == FETCH) && w_ir_free && !rst;
        imem_addr   = r_pc;
        instr       = r_valid ? r_ir : NOP_WORD;
        pc_plus2    = r_pc_plus2;
        instr_valid = r_valid;
        fetch_err   = r_err;
        halted      = (r_state == HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_ir       <= NOP_WORD;
            r_valid    <= 1'b0;
            r_pc_plus2 <= RESET_PC + 16'd2;
            r_err      <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (w_redir) begin
                r_valid <= 1'b0;
                r_ir    <= NOP_WORD;
                if (w_misaligned)
                    r_err <= 1'b1;
            end else if (w_capture) begin
                r_ir       <= imem_data;
                r_valid    <= 1'b1;
                r_pc_plus2 <= w_pc_plus2;
            end else if (w_consume || (w_next_state == HALTED)) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a configurable-latency memory model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt_in;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_stall;
    logic        imem_done;
    logic [15:0] instr;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        fetch_err;
    logic        halted;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // memory model controls, driven from the stimulus process
    logic       force_stall;
    logic [3:0] cfg_lat;
    // memory model state, owned by the memory process
    logic       pend;
    logic [3:0] cnt;
    logic [15:0] saddr;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall_in    (stall_in),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_in     (halt_in),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_data   (imem_data),
        .imem_stall  (imem_stall),
        .imem_done   (imem_done),
        .instr       (instr),
        .pc_plus2    (pc_plus2),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return 16'h4000 | (a >> 1);
    endfunction

    assign imem_stall = force_stall;
    assign imem_done  = ((cfg_lat == 4'd0) && imem_rd && !imem_stall) || (pend && (cnt == 4'd1));
    assign imem_data  = pend ? word_at(saddr) : word_at(imem_addr);

    always @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (pend) begin
            if (cnt == 4'd1) pend <= 1'b0;
            else             cnt  <= cnt - 4'd1;
        end else if (imem_rd && !imem_stall && (cfg_lat != 4'd0)) begin
            pend  <= 1'b1;
            cnt   <= cfg_lat;
            saddr <= imem_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // One clock: score any consumption at the falling edge, then step past the rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (!rst && instr_valid && !stall_in) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = 'x;
            check("sb_instr", {16'h0, instr}, {16'h0, e.instr});
            check("sb_pc_plus2", {16'h0, pc_plus2}, {16'h0, e.pc2});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] i, input logic [15:0] p);
        exp_t e;
        e.instr = i;
        e.pc2   = p;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        halt_in = 1'b0; force_stall = 1'b0; cfg_lat = 4'd0;
        cyc(); cyc();

        // reset state
        #1;
        check("rst_valid", {31'h0, instr_valid}, 32'd0);
        check("rst_instr", {16'h0, instr}, 32'h0800);
        check("rst_addr", {16'h0, imem_addr}, 32'h0000);
        check("rst_pc_plus2", {16'h0, pc_plus2}, 32'h0002);
        check("rst_imem_rd", {31'h0, imem_rd}, 32'd0);
        check("rst_halted", {30'h0, halted, fetch_err}, 32'd0);

        // zero-wait stream of three words
        push(16'h4000, 16'h0002); push(16'h4001, 16'h0004); push(16'h4002, 16'h0006);
        rst = 1'b0;
        #1;
        check("z_first_rd", {15'h0, imem_rd, imem_addr}, {15'h0, 1'b1, 16'h0000});
        check("z_no_valid_yet", {31'h0, instr_valid}, 32'd0);
        cyc();
        check("z_valid_c2", {31'h0, instr_valid}, 32'd1);
        cyc();
        cyc();
        stall_in = 1'b1;

        // downstream stall holds the IR
        for (int i = 0; i < 4; i++) begin
            #1;
            check("st_instr", {16'h0, instr}, 32'h4002);
            check("st_pc_plus2", {16'h0, pc_plus2}, 32'h0006);
            check("st_imem_rd", {31'h0, imem_rd}, 32'd0);
            cyc();
        end
        stall_in = 1'b0;
        cfg_lat = 4'd2;
        #1;
        check("st_release_rd", {15'h0, imem_rd, imem_addr}, {15'h0, 1'b1, 16'h0006});
        cyc();

        // redirect while waiting on 0x0006: late data must be dropped
        redirect = 1'b1; redirect_pc = 16'h0100;
        #1;
        check("wt_imem_rd", {31'h0, imem_rd}, 32'd0);
        cyc();
        redirect = 1'b0;
        #1;
        check("dr_done_seen", {30'h0, imem_done, imem_rd}, {30'h0, 1'b1, 1'b0});
        cyc();
        force_stall = 1'b1;

        // memory stall for three cycles, then a two-cycle completion
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ms_addr", {15'h0, imem_rd, imem_addr}, {15'h0, 1'b1, 16'h0100});
            check("ms_valid", {31'h0, instr_valid}, 32'd0);
            cyc();
        end
        force_stall = 1'b0;
        cyc();
        check("ms_wait_valid", {31'h0, instr_valid}, 32'd0);
        cyc();
        check("ms_wait_valid2", {31'h0, instr_valid}, 32'd0);
        push(16'h4080, 16'h0102);
        cyc();
        stall_in = 1'b1;
        #1;
        check("ms_capture", {15'h0, instr_valid, instr}, {15'h0, 1'b1, 16'h4080});
        cyc();
        check("ms_single_capture", {15'h0, instr_valid, instr}, {15'h0, 1'b1, 16'h4080});

        // consume with redirect to 0x0010, then halt on consumption there
        cfg_lat = 4'd0; stall_in = 1'b0; redirect = 1'b1; redirect_pc = 16'h0010;
        cyc();
        redirect = 1'b0;
        push(16'h4008, 16'h0012);
        #1;
        check("h_addr", {15'h0, imem_rd, imem_addr}, {15'h0, 1'b1, 16'h0010});
        cyc();
        halt_in = 1'b1;
        check("h_held", {15'h0, instr_valid, instr}, {15'h0, 1'b1, 16'h4008});
        cyc();
        halt_in = 1'b0;
        check("h_halted", {30'h0, halted, instr_valid}, {30'h0, 1'b1, 1'b0});
        for (int i = 0; i < 20; i++) begin
            #1;
            check("h_no_rd", {31'h0, imem_rd}, 32'd0);
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        force_stall = 1'b1;
        check("h_rst", {14'h0, halted, instr_valid, imem_addr}, 32'h0000_0000);

        // misaligned redirect halts with an error
        redirect = 1'b1; redirect_pc = 16'h0203;
        cyc();
        redirect = 1'b0;
        #1;
        check("err_flags", {30'h0, fetch_err, halted}, 32'd3);
        check("err_no_rd", {31'h0, imem_rd}, 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        force_stall = 1'b0;
        check("err_cleared", {30'h0, fetch_err, halted}, 32'd0);

        // redirect beats a simultaneous halt
        stall_in = 1'b1;
        push(16'h4000, 16'h0002);
        cyc();
        stall_in = 1'b0; halt_in = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
        cyc();
        halt_in = 1'b0; redirect = 1'b0;
        #1;
        check("rh_not_halted", {31'h0, halted}, 32'd0);
        check("rh_addr", {15'h0, imem_rd, imem_addr}, {15'h0, 1'b1, 16'h0040});
        push(16'h4020, 16'h0042);
        cyc();

        // PC wraps from 0xFFFE to 0x0000
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        cyc();
        redirect = 1'b0;
        push(16'h7FFF, 16'h0000);
        cyc();
        force_stall = 1'b1;
        #1;
        check("wrap_instr", {15'h0, instr_valid, instr}, {15'h0, 1'b1, 16'h7FFF});
        check("wrap_pc", {imem_addr, pc_plus2}, 32'h0000_0000);
        cyc();
        check("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
